mxint_stream_cast: RTL and testbench
====================================

MXINT_STREAM_CAST -- requirements
Module: mxint_stream_cast

Interface
REQ-001 SHALL have parameter IN_MAN_WIDTH, default 8, signed input mantissa width.
REQ-002 SHALL have parameter IN_EXP_WIDTH, default 8, signed input exponent width.
REQ-003 SHALL have parameter OUT_MAN_WIDTH, default 4, signed output mantissa width.
REQ-004 SHALL have parameter OUT_EXP_WIDTH, default 8, signed output exponent width.
REQ-005 SHALL have parameter BLOCK_SIZE, default 4, mantissas sharing one exponent.
REQ-006 SHALL have parameter PARALLELISM, default 2, mantissas per beat; BLOCK_SIZE % PARALLELISM == 0; NUM_BEATS = BLOCK_SIZE/PARALLELISM.
REQ-007 SHALL have parameter ROUND_NEAREST, default 0, 0 = truncate, 1 = round half-up.
REQ-008 SHALL have one clock and a synchronous, active-low reset: clk  input  1  clock; rst  input  1  synchronous active-low reset.
REQ-009 mdata_in  input  IN_MAN_WIDTH x [PARALLELISM] unpacked  one beat of mantissas.
REQ-010 edata_in  input  IN_EXP_WIDTH  block exponent, same on every beat of a block; sampled on the first beat.
REQ-011 data_in_valid input 1, data_in_ready output 1  input valid/ready handshake.
REQ-012 mdata_out  output  OUT_MAN_WIDTH x [PARALLELISM] unpacked; edata_out  output  OUT_EXP_WIDTH.
REQ-013 data_out_valid output 1, data_out_ready input 1  output valid/ready handshake.

Function
REQ-014 SHALL hold two ping-pong banks of NUM_BEATS beats each; every bank is EMPTY, FILLING or FULL.
REQ-015 Write side SHALL fill one bank per block; data_in_ready = 1 iff the write bank is EMPTY or FILLING.
REQ-016 During fill SHALL track L = bit position of the MSB of max|mantissa| plus 1 over all beats; all-zero block gives L = 0; -2^(IN_MAN_WIDTH-1) gives L = IN_MAN_WIDTH.
REQ-017 On the last accepted beat the bank SHALL go FULL, storing E = sat_OUT_EXP(ein + L - (OUT_MAN_WIDTH-1)) with exact intermediate width, and the write pointer SHALL toggle.
REQ-018 Read side SHALL drain the oldest FULL bank one beat per handshake, presenting edata_out = E on every beat; the bank becomes EMPTY after beat NUM_BEATS-1 is accepted.
REQ-019 Per lane, s = E - ein: s >= 0 arithmetic right shift by s, s < 0 left shift by |s|; then saturate to signed OUT_MAN_WIDTH.
REQ-020 With ROUND_NEAREST = 1 and s > 0, SHALL add 2^(s-1) before shifting; s <= 0 is unaffected.
REQ-021 Latency: first output beat valid the cycle after the last input beat is accepted; steady-state throughput is one beat per cycle.
REQ-022 A bank freed and another filled in the same cycle SHALL both take effect; no bubble.
REQ-023 While data_out_valid && !data_out_ready, all outputs SHALL stay stable.

Reset
REQ-024 On rst == 0 at a clk edge: both banks EMPTY, pointers 0, beat counters 0, running L = 0, data_out_valid = 0, data_in_ready = 1 after reset releases.
REQ-025 Reset mid-block SHALL discard partial and full banks; mdata_out and edata_out are don't-care while data_out_valid = 0.

Configuration
REQ-026 With MXINT_STREAM_CAST_SAT_CNT_EN defined SHALL add output sat_count [15:0], counting accepted output mantissas that saturated, sticking at 16'hFFFF, cleared by reset; without it the port and logic SHALL be absent.

Structure
REQ-027 Package mxint_cast_pkg SHALL hold the bank state enum (EMPTY/FILLING/FULL), the 3-input max function and the L/E width constants.
REQ-028 Per-lane shift/round/saturate SHALL be sub-module mxint_shift_round_sat, instantiated PARALLELISM times.

Verification (defaults)
REQ-029 Block {64,-3,10,1}, ein = 0, truncate -> edata_out = 4, mdata_out {4,-1,0,0}; ROUND_NEAREST = 1 -> {4,0,1,0}.
REQ-030 Block {127,0,0,0}, ein = 0, ROUND_NEAREST = 1 -> E = 4, mantissa 8 saturates to 7, sat_count = 1 with the macro.
REQ-031 Block {1,0,0,0}, ein = 0 -> E = -2, left shift, mdata_out {4,0,0,0}; all-zero block ein = 0 -> E = -3, zeros.
REQ-032 Block {64,0,0,0}, ein = 125 -> E clamps to 127, s = 2, mantissa 16 saturates to 7.
REQ-033 Three back-to-back blocks with data_out_ready held 0: data_in_ready drops after block 2; blocks release in order with stable outputs once ready rises.
REQ-034 Reset asserted after one beat of a block -> no output beat; the next full block is processed correctly.

Source files
------------

// File: rtl/mxint_cast_pkg.sv
// Shared types and helpers for the MXINT stream cast: bank state, exponent-scale width and a 3-way max.
package mxint_cast_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    // Width of the leading-bit position L; covers input mantissas up to 255 bits.
    localparam int unsigned L_WIDTH = 8;
    // Extra headroom bits so ein + L - (OUT_MAN_WIDTH-1) is computed exactly.
    localparam int unsigned E_GUARD = 2;

    function automatic logic [L_WIDTH-1:0] max3(
        input logic [L_WIDTH-1:0] a,
        input logic [L_WIDTH-1:0] b,
        input logic [L_WIDTH-1:0] c
    );
        logic [L_WIDTH-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mxint_shift_round_sat.sv
// One lane of the cast: signed shift by s (right if s >= 0, left otherwise),
// optional round half-up on right shifts, then saturate to OUT_MAN_WIDTH.
module mxint_shift_round_sat #(
    parameter int IN_MAN_WIDTH  = 8,
    parameter int OUT_MAN_WIDTH = 4,
    parameter int SHIFT_WIDTH   = 9,
    parameter int ROUND_NEAREST = 0
) (
    input  logic [IN_MAN_WIDTH-1:0]  mantissa,
    input  logic [SHIFT_WIDTH-1:0]   shift,
    output logic [OUT_MAN_WIDTH-1:0] result,
    output logic                     saturated
);

    localparam int unsigned WW   = IN_MAN_WIDTH + OUT_MAN_WIDTH + 2;
    // Shifts beyond these limits cannot change the saturated result.
    localparam int unsigned LMAX = OUT_MAN_WIDTH + 1;
    localparam int unsigned RMAX = IN_MAN_WIDTH + 1;
    localparam logic signed [WW-1:0] ONE = {{(WW-1){1'b0}}, 1'b1};

    logic signed [WW-1:0] ext;
    logic signed [WW-1:0] biased;
    logic signed [WW-1:0] shifted;
    logic [WW-OUT_MAN_WIDTH:0] top;
    int s_val;
    int unsigned amt;

    always_comb begin
        ext     = {{(WW-IN_MAN_WIDTH){mantissa[IN_MAN_WIDTH-1]}}, mantissa};
        biased  = ext;
        s_val   = int'($signed(shift));
        amt     = 0;
        if (s_val < 0) begin
            amt     = (-s_val > int'(LMAX)) ? LMAX : unsigned'(-s_val);
            shifted = ext <<< amt;
        end else begin
            amt = (s_val > int'(RMAX)) ? RMAX : unsigned'(s_val);
            if (ROUND_NEAREST != 0 && amt != 0) begin
                biased = ext + (ONE << (amt - 1));
            end
            shifted = biased >>> amt;
        end
        top       = shifted[WW-1:OUT_MAN_WIDTH-1];
        saturated = !((&top) || !(|top));
        result    = saturated ? {shifted[WW-1], {(OUT_MAN_WIDTH-1){~shifted[WW-1]}}}
                              : shifted[OUT_MAN_WIDTH-1:0];
    end

endmodule

// File: rtl/mxint_stream_cast.sv
// MXINT block-format stream cast with two ping-pong block banks.
// Define MXINT_STREAM_CAST_SAT_CNT_EN to add the sat_count saturation counter port.
module mxint_stream_cast
    import mxint_cast_pkg::*;
#(
    parameter int IN_MAN_WIDTH  = 8,
    parameter int IN_EXP_WIDTH  = 8,
    parameter int OUT_MAN_WIDTH = 4,
    parameter int OUT_EXP_WIDTH = 8,
    parameter int BLOCK_SIZE    = 4,
    parameter int PARALLELISM   = 2,
    parameter int ROUND_NEAREST = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_MAN_WIDTH-1:0]  mdata_in [PARALLELISM],
    input  logic [IN_EXP_WIDTH-1:0]  edata_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic [OUT_MAN_WIDTH-1:0] mdata_out [PARALLELISM],
    output logic [OUT_EXP_WIDTH-1:0] edata_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ready
`ifdef MXINT_STREAM_CAST_SAT_CNT_EN
    ,
    output logic [15:0]              sat_count
`endif
);

    localparam int NUM_BEATS   = BLOCK_SIZE / PARALLELISM;
    localparam int CNT_W       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int EXP_MAX_W   = (IN_EXP_WIDTH > OUT_EXP_WIDTH) ? IN_EXP_WIDTH : OUT_EXP_WIDTH;
    localparam int EI_WIDTH    = EXP_MAX_W + L_WIDTH + E_GUARD;
    localparam int SHIFT_WIDTH = EXP_MAX_W + 1;

    bank_state_t              state [2];
    logic                     wp, rp;
    logic [CNT_W-1:0]         wcnt, rcnt;
    logic [L_WIDTH-1:0]       lrun, l_new;
    logic [L_WIDTH-1:0]       lane_l [PARALLELISM];
    logic [IN_MAN_WIDTH-1:0]  lane_mag [PARALLELISM];
    logic [IN_MAN_WIDTH-1:0]  mem [2][NUM_BEATS][PARALLELISM];
    logic [IN_EXP_WIDTH-1:0]  ein_bank [2];
    logic [OUT_EXP_WIDTH-1:0] e_bank [2];
    logic [IN_EXP_WIDTH-1:0]  ein_cur;
    logic signed [EI_WIDTH-1:0] e_int;
    logic [EI_WIDTH-OUT_EXP_WIDTH:0] e_top;
    logic [OUT_EXP_WIDTH-1:0] e_sat;
    logic [SHIFT_WIDTH-1:0]   shift;
    logic [PARALLELISM-1:0]   lane_sat;
    logic                     in_fire, out_fire, w_last, r_last;

    assign data_in_ready  = (state[wp] != FULL);
    assign data_out_valid = (state[rp] == FULL);
    assign in_fire        = data_in_valid && data_in_ready;
    assign out_fire       = data_out_valid && data_out_ready;
    assign w_last         = (wcnt == CNT_W'(NUM_BEATS - 1));
    assign r_last         = (rcnt == CNT_W'(NUM_BEATS - 1));
    assign edata_out      = e_bank[rp];

    // L per lane: position of the highest set bit of |m|, plus one.
    always_comb begin
        for (int unsigned i = 0; i < PARALLELISM; i++) begin
            lane_mag[i] = mdata_in[i][IN_MAN_WIDTH-1] ? (~mdata_in[i] + 1'b1) : mdata_in[i];
            lane_l[i]   = '0;
            for (int unsigned b = 0; b < IN_MAN_WIDTH; b++) begin
                if (lane_mag[i][b]) lane_l[i] = L_WIDTH'(b + 1);
            end
        end
    end

    always_comb begin
        l_new = lrun;
        for (int unsigned i = 0; i < PARALLELISM; i += 2) begin
            l_new = max3(l_new, lane_l[i], lane_l[(i + 1 < PARALLELISM) ? i + 1 : i]);
        end
    end

    always_comb begin
        ein_cur = (wcnt == '0) ? edata_in : ein_bank[wp];
        e_int   = $signed({{(EI_WIDTH-IN_EXP_WIDTH){ein_cur[IN_EXP_WIDTH-1]}}, ein_cur})
                + $signed({{(EI_WIDTH-L_WIDTH){1'b0}}, l_new})
                - $signed(EI_WIDTH'(OUT_MAN_WIDTH - 1));
        e_top   = e_int[EI_WIDTH-1:OUT_EXP_WIDTH-1];
        if ((&e_top) || !(|e_top)) begin
            e_sat = e_int[OUT_EXP_WIDTH-1:0];
        end else begin
            e_sat = {e_int[EI_WIDTH-1], {(OUT_EXP_WIDTH-1){~e_int[EI_WIDTH-1]}}};
        end
    end

    always_comb begin
        shift = {{(SHIFT_WIDTH-OUT_EXP_WIDTH){e_bank[rp][OUT_EXP_WIDTH-1]}}, e_bank[rp]}
              - {{(SHIFT_WIDTH-IN_EXP_WIDTH){ein_bank[rp][IN_EXP_WIDTH-1]}}, ein_bank[rp]};
    end

    // Write bank is never FULL and read bank always is, so both updates may land in one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
            wp       <= 1'b0;
            rp       <= 1'b0;
            wcnt     <= '0;
            rcnt     <= '0;
            lrun     <= '0;
        end else begin
            if (in_fire) begin
                if (w_last) begin
                    state[wp] <= FULL;
                    wp        <= ~wp;
                    wcnt      <= '0;
                    lrun      <= '0;
                end else begin
                    state[wp] <= FILLING;
                    wcnt      <= wcnt + 1'b1;
                    lrun      <= l_new;
                end
            end
            if (out_fire) begin
                if (r_last) begin
                    state[rp] <= EMPTY;
                    rp        <= ~rp;
                    rcnt      <= '0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wp][wcnt] <= mdata_in;
            if (wcnt == '0) ein_bank[wp] <= edata_in;
            if (w_last) e_bank[wp] <= e_sat;
        end
    end

    for (genvar g = 0; g < PARALLELISM; g++) begin : g_lane
        mxint_shift_round_sat #(
            .IN_MAN_WIDTH (IN_MAN_WIDTH),
            .OUT_MAN_WIDTH(OUT_MAN_WIDTH),
            .SHIFT_WIDTH  (SHIFT_WIDTH),
            .ROUND_NEAREST(ROUND_NEAREST)
        ) u_lane (
            .mantissa (mem[rp][rcnt][g]),
            .shift    (shift),
            .result   (mdata_out[g]),
            .saturated(lane_sat[g])
        );
    end

`ifdef MXINT_STREAM_CAST_SAT_CNT_EN
    logic [16:0] sat_sum;

    always_comb begin
        sat_sum = {1'b0, sat_count};
        for (int unsigned i = 0; i < PARALLELISM; i++) begin
            sat_sum = sat_sum + 17'(lane_sat[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sat_count <= '0;
        end else if (out_fire) begin
            sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^lane_sat;
`endif

endmodule

// File: tb/tb_mxint_stream_cast.sv
// Scoreboard bench: a truncating and a rounding instance share one input stream and
// are checked against an integer reference model.
module tb_mxint_stream_cast;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] mdata_in [2];
    logic [7:0] edata_in;
    logic       data_in_valid;
    logic       data_out_ready;
    logic       in_ready_t, in_ready_r;
    logic [3:0] mout_t [2];
    logic [3:0] mout_r [2];
    logic [7:0] eout_t, eout_r;
    logic       vout_t, vout_r;
`ifdef MXINT_STREAM_CAST_SAT_CNT_EN
    logic [15:0] satc_t, satc_r;
`endif

    mxint_stream_cast #(.ROUND_NEAREST(0)) dut_t (
        .clk(clk), .rst(rst),
        .mdata_in(mdata_in), .edata_in(edata_in),
        .data_in_valid(data_in_valid), .data_in_ready(in_ready_t),
        .mdata_out(mout_t), .edata_out(eout_t),
        .data_out_valid(vout_t), .data_out_ready(data_out_ready)
`ifdef MXINT_STREAM_CAST_SAT_CNT_EN
        , .sat_count(satc_t)
`endif
    );

    mxint_stream_cast #(.ROUND_NEAREST(1)) dut_r (
        .clk(clk), .rst(rst),
        .mdata_in(mdata_in), .edata_in(edata_in),
        .data_in_valid(data_in_valid), .data_in_ready(in_ready_r),
        .mdata_out(mout_r), .edata_out(eout_r),
        .data_out_valid(vout_r), .data_out_ready(data_out_ready)
`ifdef MXINT_STREAM_CAST_SAT_CNT_EN
        , .sat_count(satc_r)
`endif
    );

    typedef struct packed {
        logic [7:0] e;
        logic [3:0] t0, t1, r0, r1;
        logic [1:0] st, sr;
    } beat_t;

    beat_t sb [$];
    beat_t x;
    int passed = 0;
    int failed = 0;
    int total  = 0;
    int sat_exp_t = 0;
    int sat_exp_r = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int calc_l(input int a, input int b, input int c, input int d);
        int mx, l;
        int v [4];
        v = '{a, b, c, d};
        mx = 0;
        for (int i = 0; i < 4; i++) begin
            if ((v[i] < 0 ? -v[i] : v[i]) > mx) mx = (v[i] < 0 ? -v[i] : v[i]);
        end
        l = 0;
        while (l < 31 && (1 << l) <= mx) l++;
        return l;
    endfunction

    function automatic int calc_e(input int l, input int ein);
        int e;
        e = ein + l - 3;
        if (e > 127) e = 127;
        if (e < -128) e = -128;
        return e;
    endfunction

    function automatic longint lane_raw(input int m, input int s, input bit rnd);
        longint v;
        int k;
        v = longint'(m);
        if (s >= 0) begin
            k = (s > 40) ? 40 : s;
            if (rnd && k > 0) v = v + (longint'(1) << (k - 1));
            v = v >>> k;
        end else begin
            k = (-s > 40) ? 40 : -s;
            v = v <<< k;
        end
        return v;
    endfunction

    function automatic logic [3:0] sat4(input longint v);
        if (v > 7) return 4'd7;
        if (v < -8) return 4'b1000;
        return 4'(v);
    endfunction

    function automatic int is_sat(input longint v);
        return (v > 7 || v < -8) ? 1 : 0;
    endfunction

    task automatic send_block(input int m0, input int m1, input int m2, input int m3, input int ein);
        int m [4];
        int e, s, guard;
        bit acc;
        beat_t bt;
        m = '{m0, m1, m2, m3};
        e = calc_e(calc_l(m0, m1, m2, m3), ein);
        s = e - ein;
        for (int b = 0; b < 2; b++) begin
            bt.e  = 8'(e);
            bt.t0 = sat4(lane_raw(m[2*b], s, 1'b0));
            bt.t1 = sat4(lane_raw(m[2*b+1], s, 1'b0));
            bt.r0 = sat4(lane_raw(m[2*b], s, 1'b1));
            bt.r1 = sat4(lane_raw(m[2*b+1], s, 1'b1));
            bt.st = 2'(is_sat(lane_raw(m[2*b], s, 1'b0)) + is_sat(lane_raw(m[2*b+1], s, 1'b0)));
            bt.sr = 2'(is_sat(lane_raw(m[2*b], s, 1'b1)) + is_sat(lane_raw(m[2*b+1], s, 1'b1)));
            sb.push_back(bt);
        end
        for (int b = 0; b < 2; b++) begin
            mdata_in[0]   = 8'(m[2*b]);
            mdata_in[1]   = 8'(m[2*b+1]);
            edata_in      = 8'(ein);
            data_in_valid = 1'b1;
            guard = 0;
            acc   = 1'b0;
            while (!acc && guard < 200) begin
                @(negedge clk);
                acc = in_ready_t;
                guard++;
                @(posedge clk);
                #1;
            end
            chk("in_accept", 32'(acc), 1);
        end
        data_in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain", 32'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_sat();
`ifdef MXINT_STREAM_CAST_SAT_CNT_EN
        chk("sat_count_t", 32'(satc_t), 32'(sat_exp_t));
        chk("sat_count_r", 32'(satc_r), 32'(sat_exp_r));
`endif
    endtask

    // Output monitor: pops on each accepted beat and checks stability across stalls.
    logic       stall_prev = 1'b0;
    logic [7:0] pe_t, pe_r;
    logic [3:0] pt0, pt1, pr0, pr1;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (stall_prev) begin
                chk("stall_valid", 32'(vout_t), 1);
                chk("stall_e", {pe_r, pe_t}, {eout_r, eout_t});
                chk("stall_m", {pt0, pt1, pr0, pr1}, {mout_t[0], mout_t[1], mout_r[0], mout_r[1]});
            end
            if (vout_t && data_out_ready) begin
                chk("valid_pair", 32'(vout_r), 1);
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    x = sb.pop_front();
                    chk("edata_t", 32'(eout_t), 32'(x.e));
                    chk("edata_r", 32'(eout_r), 32'(x.e));
                    chk("mdata_t", {mout_t[0], mout_t[1]}, {x.t0, x.t1});
                    chk("mdata_r", {mout_r[0], mout_r[1]}, {x.r0, x.r1});
                    sat_exp_t = sat_exp_t + int'(x.st);
                    sat_exp_r = sat_exp_r + int'(x.sr);
                end
            end
            stall_prev = vout_t && !data_out_ready;
            pe_t = eout_t;
            pe_r = eout_r;
            pt0  = mout_t[0];
            pt1  = mout_t[1];
            pr0  = mout_r[0];
            pr1  = mout_r[1];
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r [4];
        int ein;
        rst            = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        mdata_in[0]    = '0;
        mdata_in[1]    = '0;
        edata_in       = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid_t", 32'(vout_t), 0);
        chk("rst_valid_r", 32'(vout_r), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_t", 32'(in_ready_t), 1);
        chk("rst_in_ready_r", 32'(in_ready_r), 1);
        @(posedge clk);
        #1;

        // Basic block, first-beat latency
        send_block(64, -3, 10, 1, 0);
        @(negedge clk);
        chk("latency_valid", 32'(vout_t), 1);
        drain();

        // Rounding overflow, left shifts, all-zero, exponent clamp high/low, most-negative mantissa
        send_block(127, 0, 0, 0, 0);
        send_block(1, 0, 0, 0, 0);
        send_block(0, 0, 0, 0, 0);
        send_block(64, 0, 0, 0, 125);
        send_block(1, 0, 0, 0, -128);
        send_block(-128, 5, 0, 0, 0);
        drain();
        check_sat();

        // Two full banks with the output stalled, then a third block
        data_out_ready = 1'b0;
        send_block(100, -7, 33, 2, 3);
        send_block(-20, 9, 0, 1, -4);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready_t), 0);
        repeat (4) @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        send_block(5, -6, 7, -8, 10);
        drain();

        // Random blocks streamed back to back
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) r[i] = (int'($urandom_range(0, 255)) - 128) >>> $urandom_range(0, 6);
            ein = int'($urandom_range(0, 60)) - 30;
            send_block(r[0], r[1], r[2], r[3], ein);
        end
        drain();
        check_sat();

        // Reset after one beat discards the partial block
        mdata_in[0]   = 8'd90;
        mdata_in[1]   = 8'd12;
        edata_in      = 8'd0;
        data_in_valid = 1'b1;
        @(negedge clk);
        chk("partial_accept", 32'(in_ready_t), 1);
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sat_exp_t = 0;
        sat_exp_r = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_out_after_rst", 32'(vout_t), 0);
        end
        @(posedge clk);
        #1;
        send_block(100, -50, 3, -7, -10);
        drain();
        check_sat();
        @(negedge clk);
        chk("end_in_ready", 32'(in_ready_t), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
